// File: rtl/prog_rom_loader.sv
// Program memory for the CPU fetch port, filled from a valid/ready byte stream.
// The CPU is held in reset until a complete program has been loaded.
module prog_rom_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    input  logic [ADDR_W-1:0] rom_address,
    output logic [DATA_W-1:0] opcode1,
    output logic [DATA_W-1:0] opcode2,
    output logic              cpu_reset
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0] opcode1_q, opcode1_d;
    logic [DATA_W-1:0] opcode2_q, opcode2_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr_hi;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        wr_en       = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (ld_start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    // A zero length selects the whole memory, hence the extra counter bit.
                    remaining_d = (ld_len == '0) ? (ADDR_W+1)'(DEPTH) : {1'b0, ld_len};
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    wr_en       = 1'b1;
                    wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W+1)'(1);
                    if (remaining_q == (ADDR_W+1)'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_addr_hi = rom_address + ADDR_W'(1);
        opcode1_d  = '0;
        opcode2_d  = '0;
        // Outside RUN the CPU sees the all-zero no-op opcode.
        if (state_q == RUN) begin
            opcode1_d = mem[rom_address];
            opcode2_d = mem[rd_addr_hi];
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            opcode1_q   <= '0;
            opcode2_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
            opcode1_q   <= opcode1_d;
            opcode2_q   <= opcode2_d;
        end
    end

    // Memory has no reset so a program survives an aborted or repeated load.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= ld_data;
        end
    end

    assign ld_ready  = (state_q == LOAD);
    assign ld_done   = (state_q == DONE);
    assign cpu_reset = (state_q != RUN);
    assign opcode1   = opcode1_q;
    assign opcode2   = opcode2_q;

endmodule

// File: tb/tb_prog_rom_loader.sv
// Directed bench for prog_rom_loader: loads programs, then checks fetches
// against a byte model through an expected-value queue.
module tb_prog_rom_loader;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic       ld_start = 1'b0;
    logic [7:0] ld_len = 8'd0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'd0;
    logic       ld_ready;
    logic       ld_done;
    logic [7:0] rom_address = 8'd0;
    logic [7:0] opcode1;
    logic [7:0] opcode2;
    logic       cpu_reset;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  model_mem [256];
    logic [7:0]  load_buf [256];
    logic [15:0] exp_q [$];

    prog_rom_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .ld_start   (ld_start),
        .ld_len     (ld_len),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .rom_address(rom_address),
        .opcode1    (opcode1),
        .opcode2    (opcode2),
        .cpu_reset  (cpu_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] addr);
        logic [7:0] hi;
        hi = addr + 8'd1;
        rom_address = addr;
        exp_q.push_back({model_mem[addr], model_mem[hi]});
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] expv;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, {opcode1, opcode2}, 16'hxxxx);
        end else begin
            expv = exp_q.pop_front();
            chk(tag, {opcode1, opcode2}, expv);
        end
    endtask

    task automatic fetch(input string tag, input logic [7:0] addr);
        applyStimulus(addr);
        @(negedge clk);
        checkOutput(tag);
    endtask

    // Called at a negedge; returns at the first negedge of RUN.
    task automatic do_load(input logic [7:0] len, input int n, input bit gaps,
                           input bit valid_on_start);
        int acc = 0;
        int cyc = 0;
        ld_start = 1'b1;
        ld_len   = len;
        ld_valid = valid_on_start;
        ld_data  = 8'hEE;
        @(negedge clk);
        ld_start = 1'b0;
        while (acc < n && cyc < 2000) begin
            chk("ld_ready_load", {15'd0, ld_ready}, 16'd1);
            chk("ld_done_load", {15'd0, ld_done}, 16'd0);
            chk("cpu_reset_load", {15'd0, cpu_reset}, 16'd1);
            if (cyc > 0) chk("ops_load", {opcode1, opcode2}, 16'h0000);
            ld_valid = gaps ? (cyc % 2 == 1) : 1'b1;
            ld_data  = load_buf[acc];
            @(posedge clk);
            if (ld_valid) begin
                model_mem[acc] = ld_data;
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        ld_valid = 1'b0;
        if (acc < n) chk("load_timeout", 16'(acc), 16'(n));
        chk("ld_done_pulse", {15'd0, ld_done}, 16'd1);
        chk("ld_ready_done", {15'd0, ld_ready}, 16'd0);
        chk("cpu_reset_done", {15'd0, cpu_reset}, 16'd1);
        chk("ops_done", {opcode1, opcode2}, 16'h0000);
        @(negedge clk);
        chk("ld_done_run", {15'd0, ld_done}, 16'd0);
        chk("cpu_reset_run", {15'd0, cpu_reset}, 16'd0);
        chk("ld_ready_run", {15'd0, ld_ready}, 16'd0);
        chk("ops_run_first", {opcode1, opcode2}, 16'h0000);
    endtask

    initial begin
        // T1: asynchronous reset mid-cycle
        repeat (2) @(posedge clk);
        #3 n_reset = 1'b0;
        #1;
        chk("rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        chk("rst_ld_ready", {15'd0, ld_ready}, 16'd0);
        chk("rst_ld_done", {15'd0, ld_done}, 16'd0);
        chk("rst_ops", {opcode1, opcode2}, 16'h0000);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        chk("idle_cpu_reset", {15'd0, cpu_reset}, 16'd1);

        // T2: four-byte load, aligned fetches
        $display("[TB] T2 basic load");
        load_buf[0] = 8'h12; load_buf[1] = 8'h34; load_buf[2] = 8'h56; load_buf[3] = 8'h78;
        do_load(8'd4, 4, 1'b0, 1'b0);
        fetch("t2_addr0", 8'h00);
        fetch("t2_addr2", 8'h02);

        // T3: gapped valid; mem[3] must still hold 78
        $display("[TB] T3 valid gaps");
        load_buf[0] = 8'hAA; load_buf[1] = 8'hBB; load_buf[2] = 8'hCC;
        do_load(8'd3, 3, 1'b1, 1'b0);
        fetch("t3_addr0", 8'h00);
        fetch("t3_addr2", 8'h02);
        fetch("t3_addr1_odd", 8'h01);

        // T4: full-memory load and address wrap
        $display("[TB] T4 full load");
        for (int i = 0; i < 256; i++) load_buf[i] = 8'(i);
        do_load(8'd0, 256, 1'b0, 1'b0);
        fetch("t4_wrap", 8'hFF);
        fetch("t4_addr10", 8'h10);
        fetch("t4_addr81", 8'h81);

        // T5: reload from RUN, start-cycle byte must be ignored
        $display("[TB] T5 reload");
        load_buf[0] = 8'h5A; load_buf[1] = 8'hA5;
        do_load(8'd2, 2, 1'b0, 1'b1);
        fetch("t5_addr0", 8'h00);
        fetch("t5_addr2", 8'h02);

        // T6: reset after two of four bytes
        $display("[TB] T6 abort");
        ld_start = 1'b1;
        ld_len   = 8'd4;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'hC0 + 8'(i);
            @(posedge clk);
            model_mem[i] = ld_data;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        n_reset  = 1'b0;
        #1;
        chk("t6_ld_done", {15'd0, ld_done}, 16'd0);
        chk("t6_ld_ready", {15'd0, ld_ready}, 16'd0);
        chk("t6_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        @(negedge clk);
        n_reset  = 1'b1;
        ld_valid = 1'b1;
        @(negedge clk);
        chk("t6_idle_ready", {15'd0, ld_ready}, 16'd0);
        chk("t6_idle_done", {15'd0, ld_done}, 16'd0);
        @(negedge clk);
        chk("t6_idle_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        ld_valid = 1'b0;
        load_buf[0] = 8'h11; load_buf[1] = 8'h22; load_buf[2] = 8'h33; load_buf[3] = 8'h44;
        do_load(8'd4, 4, 1'b0, 1'b0);
        fetch("t6_addr0", 8'h00);
        fetch("t6_addr2", 8'h02);
        fetch("t6_addr4", 8'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
